key_lut_table: RTL and testbench

- Writable, registered key->data lookup table: the runtime-programmable successor to the static key-pair mux.
- Holds NR_ENTRY (valid, key, data) entries that are installed, updated or flushed at runtime.
- Serves one lookup per cycle over a valid/ready handshake and returns hit and data, or default/zero, one cycle later.
- Used in the core for small decode/CSR-remap tables that software or microcode reprograms.

---
 rtl/key_lut_table.sv | 143 ++++++++++++++
 tb/tb_key_lut_table.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_lut_table.sv
// Runtime-programmable key->data lookup table with a single-stage lookup pipeline.
// Writes update in place, fill the lowest free slot, or evict round-robin when full.
module key_lut_table #(
  parameter int NR_ENTRY    = 8,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  parameter int CNT_W       = $clog2(NR_ENTRY + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                lkp_valid,
  output logic                lkp_ready,
  input  logic [KEY_LEN-1:0]  lkp_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic [DATA_LEN-1:0] resp_data,
  output logic [CNT_W-1:0]    occupancy,
  output logic                evict
);

  localparam int IDX_W = $clog2(NR_ENTRY);

  logic [NR_ENTRY-1:0] valid_reg;
  logic [KEY_LEN-1:0]  key_reg  [NR_ENTRY];
  logic [DATA_LEN-1:0] data_reg [NR_ENTRY];
  logic [IDX_W-1:0]    ptr_reg;
  logic [CNT_W-1:0]    occ_reg;
  logic                evict_reg;
  logic                resp_valid_reg;
  logic                resp_hit_reg;
  logic [DATA_LEN-1:0] resp_data_reg;

  logic [NR_ENTRY-1:0] wr_match;
  logic [NR_ENTRY-1:0] lkp_match;
  logic                any_wr_match;
  logic                any_free;
  logic [IDX_W-1:0]    match_idx;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic                wr_do;
  logic                wr_evicts;
  logic                lkp_accept;
  logic                lkp_hit;
  logic [DATA_LEN-1:0] lkp_data;
  logic [DATA_LEN-1:0] miss_data;

  genvar gi;
  generate
    for (gi = 0; gi < NR_ENTRY; gi++) begin : g_cmp
      assign wr_match[gi]  = valid_reg[gi] && (key_reg[gi] == wr_key);
      assign lkp_match[gi] = valid_reg[gi] && (key_reg[gi] == lkp_key);
    end
  endgenerate

  // Keys are unique among valid entries, so at most one match bit is set.
  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    any_free  = 1'b0;
    lkp_data  = '0;
    for (int i = NR_ENTRY - 1; i >= 0; i--) begin
      if (wr_match[i]) match_idx = i[IDX_W-1:0];
      if (!valid_reg[i]) begin
        any_free = 1'b1;
        free_idx = i[IDX_W-1:0];
      end
    end
    for (int i = 0; i < NR_ENTRY; i++) begin
      lkp_data = lkp_data | (data_reg[i] & {DATA_LEN{lkp_match[i]}});
    end
  end

  assign any_wr_match = |wr_match;
  assign lkp_hit      = |lkp_match;
  assign miss_data    = (HAS_DEFAULT != 0) ? default_out : '0;
  assign wr_do        = wr_en && !flush;
  assign wr_evicts    = wr_do && !any_wr_match && !any_free;
  assign wr_idx       = any_wr_match ? match_idx : (any_free ? free_idx : ptr_reg);
  assign lkp_ready    = !resp_valid_reg || resp_ready;
  assign lkp_accept   = lkp_valid && lkp_ready;

  always_ff @(posedge clk) begin
    if (wr_do) begin
      key_reg[wr_idx]  <= wr_key;
      data_reg[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      ptr_reg   <= '0;
      occ_reg   <= '0;
      evict_reg <= 1'b0;
    end else begin
      evict_reg <= wr_evicts;
      if (flush) begin
        valid_reg <= '0;
        ptr_reg   <= '0;
        occ_reg   <= '0;
      end else if (wr_do) begin
        valid_reg[wr_idx] <= 1'b1;
        if (!any_wr_match && any_free) begin
          occ_reg <= occ_reg + CNT_W'(1);
        end
        if (wr_evicts) begin
          ptr_reg <= (ptr_reg == IDX_W'(NR_ENTRY - 1)) ? '0 : ptr_reg + IDX_W'(1);
        end
      end
    end
  end

  // Response registers only load on accept, so a stalled response is never disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      if (lkp_accept) begin
        resp_valid_reg <= 1'b1;
        resp_hit_reg   <= lkp_hit;
        resp_data_reg  <= lkp_hit ? lkp_data : miss_data;
      end else if (resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_hit   = resp_hit_reg;
  assign resp_data  = resp_data_reg;
  assign occupancy  = occ_reg;
  assign evict      = evict_reg;

endmodule

// File: tb/tb_key_lut_table.sv
// Directed bench for key_lut_table: a behavioural table model checked every cycle,
// plus hand-computed literal expectations at the test-plan milestones.
module tb_key_lut_table;

  localparam int N  = 8;
  localparam int KL = 4;
  localparam int DL = 32;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [KL-1:0] wr_key = '0;
  logic [DL-1:0] wr_data = '0;
  logic          lkp_valid = 1'b0;
  logic          lkp_ready;
  logic [KL-1:0] lkp_key = '0;
  logic [DL-1:0] default_out = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_hit;
  logic [DL-1:0] resp_data;
  logic [CW-1:0] occupancy;
  logic          evict;

  key_lut_table #(.NR_ENTRY(N), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_key(wr_key),
    .wr_data(wr_data), .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_key(lkp_key),
    .default_out(default_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_data(resp_data), .occupancy(occupancy), .evict(evict)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  // Behavioural model of the table contents and the response slot.
  bit          m_v [N];
  int unsigned m_k [N];
  int unsigned m_d [N];
  int          m_ptr = 0;
  bit          m_rv = 0;
  bit          m_hit = 0;
  int unsigned m_data = 0;
  bit          m_ev = 0;

  task automatic chk(input string name, input logic [DL-1:0] got, input logic [DL-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic int find_key(input int unsigned k);
    for (int i = 0; i < N; i++) if (m_v[i] && m_k[i] == k) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_ptr = 0; m_rv = 0; m_hit = 0; m_data = 0; m_ev = 0;
    end else begin
      int idx;
      // Lookup sees the table as it was before this cycle's write/flush.
      if (lkp_valid && (!m_rv || resp_ready)) begin
        idx = find_key(lkp_key);
        m_rv = 1;
        m_hit = (idx >= 0);
        m_data = (idx >= 0) ? m_d[idx] : default_out;
      end else if (resp_ready) begin
        m_rv = 0;
      end
      m_ev = 0;
      if (flush) begin
        for (int i = 0; i < N; i++) m_v[i] = 0;
        m_ptr = 0;
      end else if (wr_en) begin
        idx = find_key(wr_key);
        if (idx < 0) for (int i = N - 1; i >= 0; i--) if (!m_v[i]) idx = i;
        if (idx < 0) begin
          idx = m_ptr;
          m_ptr = (m_ptr + 1) % N;
          m_ev = 1;
        end
        m_v[idx] = 1; m_k[idx] = wr_key; m_d[idx] = wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      int pop;
      pop = 0;
      for (int i = 0; i < N; i++) pop += m_v[i];
      chk("occupancy", DL'(occupancy), DL'(pop));
      chk("evict", DL'(evict), DL'(m_ev));
      chk("resp_valid", DL'(resp_valid), DL'(m_rv));
      chk("lkp_ready", DL'(lkp_ready), DL'(!m_rv || resp_ready));
      if (m_rv) begin
        chk("resp_hit", DL'(resp_hit), DL'(m_hit));
        chk("resp_data", resp_data, DL'(m_data));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int unsigned k, input int unsigned d);
    wr_en = 1'b1; wr_key = KL'(k); wr_data = DL'(d);
    step();
    wr_en = 1'b0;
    $display("write key=%0d data=0x%0h occ=%0d evict=%0b", k, d, occupancy, evict);
  endtask

  task automatic do_lookup(input int unsigned k, input int unsigned dflt);
    lkp_valid = 1'b1; lkp_key = KL'(k); default_out = DL'(dflt);
    step();
    lkp_valid = 1'b0;
    $display("lookup key=%0d -> valid=%0b hit=%0b data=0x%0h", k, resp_valid, resp_hit, resp_data);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    $display("flush occ=%0d", occupancy);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("rst_occupancy", DL'(occupancy), 0);
    chk("rst_resp_valid", DL'(resp_valid), 0);
    chk("rst_evict", DL'(evict), 0);

    do_lookup(3, 32'hDEAD);
    chk("miss_hit", DL'(resp_hit), 0);
    chk("miss_data", resp_data, 32'hDEAD);
    chk("miss_occ", DL'(occupancy), 0);

    do_write(3, 32'h11);
    do_lookup(3, 32'hDEAD);
    chk("hit_11", resp_data, 32'h11);
    chk("hit_11_flag", DL'(resp_hit), 1);
    do_write(3, 32'h22);
    chk("update_occ", DL'(occupancy), 1);
    do_lookup(3, 32'hDEAD);
    chk("hit_22", resp_data, 32'h22);

    do_flush();
    for (int k = 0; k < N; k++) do_write(k, 32'h100 + k);
    chk("full_occ", DL'(occupancy), 8);
    chk("full_evict", DL'(evict), 0);
    do_write(9, 32'h99);
    chk("evict_pulse", DL'(evict), 1);
    step();
    chk("evict_clear", DL'(evict), 0);
    do_lookup(0, 32'hBEEF);
    chk("evicted_0", resp_data, 32'hBEEF);
    do_lookup(9, 32'hBEEF);
    chk("hit_9", resp_data, 32'h99);
    do_write(10, 32'hAA);
    do_lookup(1, 32'hBEEF);
    chk("evicted_1", DL'(resp_hit), 0);
    do_lookup(10, 32'hBEEF);
    chk("hit_10", resp_data, 32'hAA);
    do_lookup(2, 32'hBEEF);
    chk("kept_2", resp_data, 32'h102);

    do_flush();
    wr_en = 1'b1; wr_key = 4'd5; wr_data = 32'h55;
    do_lookup(5, 32'h777);
    wr_en = 1'b0;
    chk("rbw_miss", resp_data, 32'h777);
    do_lookup(5, 32'h777);
    chk("rbw_hit", resp_data, 32'h55);

    // Stall with a pending request and a same-key rewrite underneath.
    resp_ready = 1'b0;
    do_lookup(5, 32'h777);
    lkp_valid = 1'b1; lkp_key = 4'd7;
    wr_en = 1'b1; wr_key = 4'd5; wr_data = 32'h66;
    step();
    wr_en = 1'b0;
    chk("stall_ready", DL'(lkp_ready), 0);
    chk("stall_data1", resp_data, 32'h55);
    step(); step();
    chk("stall_data3", resp_data, 32'h55);
    chk("stall_valid", DL'(resp_valid), 1);
    $display("stall released data=0x%0h", resp_data);
    resp_ready = 1'b1;
    step();
    chk("b2b_7", resp_data, 32'h777);
    lkp_key = 4'd5;
    step();
    chk("b2b_5", resp_data, 32'h66);
    chk("b2b_valid", DL'(resp_valid), 1);
    lkp_key = 4'd7;
    step();
    chk("b2b_7b", DL'(resp_hit), 0);
    lkp_valid = 1'b0;
    step();
    chk("drain_valid", DL'(resp_valid), 0);

    do_flush();
    for (int k = 1; k <= 4; k++) do_write(k, 32'h200 + k);
    chk("occ4", DL'(occupancy), 4);
    flush = 1'b1; wr_en = 1'b1; wr_key = 4'd6; wr_data = 32'h66;
    step();
    flush = 1'b0; wr_en = 1'b0;
    chk("flushwr_occ", DL'(occupancy), 0);
    chk("flushwr_evict", DL'(evict), 0);
    do_lookup(6, 32'h5A);
    chk("flushwr_miss", DL'(resp_hit), 0);

    do_write(2, 32'h22);
    resp_ready = 1'b0;
    do_lookup(2, 32'h5A);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", DL'(resp_valid), 0);
    $display("reset asserted mid-stall resp_valid=%0b", resp_valid);
    step();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    do_lookup(2, 32'h5A);
    chk("postrst_miss", DL'(resp_hit), 0);
    chk("postrst_data", resp_data, 32'h5A);
    step();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
